// File: rtl/mvm_pkg.sv
// Shared constants and types for the matrix-vector multiplier output path.
package mvm_pkg;

  localparam int unsigned MAT_SCALE    = 12;
  localparam int unsigned INPUT_WIDTH  = 8;
  localparam int unsigned OUTPUT_WIDTH = 2 * INPUT_WIDTH;

  typedef logic signed [OUTPUT_WIDTH-1:0] word_t;
  typedef logic [$clog2(MAT_SCALE)-1:0]  idx_t;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DROP
  } cap_state_t;

endpackage

// File: rtl/mvm_out_bank.sv
// One result-vector bank: Depth-word register array, one write port, one read port, full flag.
module mvm_out_bank
  import mvm_pkg::*;
#(
  parameter int unsigned Depth     = mvm_pkg::MAT_SCALE,
  parameter int unsigned Width     = mvm_pkg::OUTPUT_WIDTH,
  parameter int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [AddrWidth-1:0]    wr_addr,
  input  logic signed [Width-1:0] wr_data,
  input  logic [AddrWidth-1:0]    rd_addr,
  output logic signed [Width-1:0] rd_data,
  input  logic                    set_full,
  input  logic                    clr_full,
  output logic                    full
);

  logic signed [Width-1:0] mem_q [Depth];
  logic                    full_q;

  // Contents need no reset: the full flag gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
    end else if (set_full) begin
      full_q <= 1'b1;
    end else if (clr_full) begin
      full_q <= 1'b0;
    end
  end

  assign rd_data = mem_q[rd_addr];
  assign full    = full_q;

endmodule

// File: rtl/mvm_out_buffer.sv
// Ping-pong buffer that captures MVM result bursts and replays them on a valid/ready stream.
// Define MVM_OUT_RELU_EN to store negative words as zero.
module mvm_out_buffer
  import mvm_pkg::*;
#(
  parameter int unsigned MAT_SCALE    = mvm_pkg::MAT_SCALE,
  parameter int unsigned OUTPUT_WIDTH = mvm_pkg::OUTPUT_WIDTH,
  parameter int unsigned IDX_WIDTH    = $clog2(MAT_SCALE)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mvm_done,
  input  logic signed [OUTPUT_WIDTH-1:0] mvm_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [OUTPUT_WIDTH-1:0] out_data,
  output logic [IDX_WIDTH-1:0]           out_index,
  output logic                           out_last,
  output logic                           busy,
  output logic                           overflow
);

  typedef logic [IDX_WIDTH-1:0] ptr_t;
  localparam ptr_t LastIdx = ptr_t'(MAT_SCALE - 1);

  cap_state_t state_q, state_d;
  ptr_t       wptr_q, wptr_d, rptr_q, rptr_d;
  logic       wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic       overflow_q, overflow_d;

  logic [1:0]                    full, wr_en, set_full, clr_full;
  logic signed [OUTPUT_WIDTH-1:0] rd_data [2];
  logic signed [OUTPUT_WIDTH-1:0] wr_data;

  always_comb begin
    wr_data = mvm_data;
`ifdef MVM_OUT_RELU_EN
    if (mvm_data[OUTPUT_WIDTH-1]) begin
      wr_data = '0;
    end
`endif
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    mvm_out_bank #(
      .Depth    (MAT_SCALE),
      .Width    (OUTPUT_WIDTH),
      .AddrWidth(IDX_WIDTH)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en[b]),
      .wr_addr (wptr_q),
      .wr_data (wr_data),
      .rd_addr (rptr_q),
      .rd_data (rd_data[b]),
      .set_full(set_full[b]),
      .clr_full(clr_full[b]),
      .full    (full[b])
    );
  end

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    overflow_d = overflow_q;
    wr_en      = '0;
    set_full   = '0;
    clr_full   = '0;

    case (state_q)
      IDLE: begin
        if (mvm_done) begin
          if (full[wr_bank_q]) begin
            state_d    = DROP;
            overflow_d = 1'b1;
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        wr_en[wr_bank_q] = 1'b1;
        if (wptr_q == LastIdx) begin
          set_full[wr_bank_q] = 1'b1;
          wr_bank_d           = ~wr_bank_q;
          wptr_d              = '0;
          state_d             = IDLE;
        end else begin
          wptr_d = wptr_q + 1'b1;
        end
      end
      DROP: begin
        // wptr doubles as the drop counter; the write bank is full so nothing is stored.
        if (wptr_q == LastIdx) begin
          wptr_d  = '0;
          state_d = IDLE;
        end else begin
          wptr_d = wptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid = full[rd_bank_q];
    if (out_valid && out_ready) begin
      if (rptr_q == LastIdx) begin
        clr_full[rd_bank_q] = 1'b1;
        rd_bank_d           = ~rd_bank_q;
        rptr_d              = '0;
      end else begin
        rptr_d = rptr_q + 1'b1;
      end
    end

    out_data  = out_valid ? rd_data[rd_bank_q] : '0;
    out_index = rptr_q;
    out_last  = out_valid && (rptr_q == LastIdx);
    busy      = (state_q == CAPTURE) || (|full);
    overflow  = overflow_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
